controlador_alarma: RTL and testbench

//  Consumes the per-sample out-of-range flag from the temperature comparator stage and turns it into a debounced alarm.

---
 rtl/pkg_temp.sv | 14 +
 rtl/divisor_parpadeo.sv | 48 ++++
 rtl/controlador_alarma.sv | 162 ++++++++++++++++
 tb/tb_controlador_alarma.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_temp.sv
// Shared types and default debounce depths for the temperature alarm path.
package pkg_temp;

    typedef enum logic [1:0] {
        NORMAL       = 2'd0,
        SOSPECHA     = 2'd1,
        ALARMA       = 2'd2,
        RECUPERACION = 2'd3
    } estado_alarma_t;

    localparam int N_ACTIVAR_DEF    = 3;
    localparam int N_DESACTIVAR_DEF = 4;

endpackage

// File: rtl/divisor_parpadeo.sv
// Blink divider: counts 0..DIV-1 while enabled and toggles a phase bit on wrap.
// fase_sig is the phase value the register takes at the next edge, so a
// downstream flop can register a function of it without an extra cycle of lag.
module divisor_parpadeo #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic fase_sig
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_prox;
    logic         fase;

    // Next count and phase; clear has priority so every run starts in phase 0.
    always_comb begin
        cnt_prox = cnt;
        fase_sig = fase;
        if (clear) begin
            cnt_prox = '0;
            fase_sig = 1'b0;
        end else if (enable) begin
            if (cnt == W'(DIV - 1)) begin
                cnt_prox = '0;
                fase_sig = ~fase;
            end else begin
                cnt_prox = cnt + 1'b1;
            end
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fase <= 1'b0;
        end else begin
            cnt  <= cnt_prox;
            fase <= fase_sig;
        end
    end

endmodule

// File: rtl/controlador_alarma.sv
// Debounced temperature alarm with acknowledge latch, blink indicator and
// saturating event counter.
//
//  state        | meaning
//  NORMAL       | in range, no alarm
//  SOSPECHA     | counting consecutive out-of-range samples
//  ALARMA       | alarm raised
//  RECUPERACION | alarm still raised, counting consecutive in-range samples
module controlador_alarma
    import pkg_temp::*;
#(
    parameter int N_ACTIVAR    = N_ACTIVAR_DEF,
    parameter int N_DESACTIVAR = N_DESACTIVAR_DEF,
    parameter int DIV_PARPADEO = 25_000_000,
    parameter int W_EVENTOS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 muestra_valida,
    input  logic                 fuera_rango,
    input  logic                 reconocer,
    output logic                 alarma,
    output logic                 no_reconocida,
    output logic                 indicador,
    output logic [W_EVENTOS-1:0] cnt_eventos
);

    localparam int W_ACT = $clog2(N_ACTIVAR + 1);
    localparam int W_DES = $clog2(N_DESACTIVAR + 1);

    estado_alarma_t       estado, estado_prox;
    logic [W_ACT-1:0]     cnt_act, cnt_act_prox;
    logic [W_DES-1:0]     cnt_des, cnt_des_prox;
    logic                 ack, ack_prox;
    logic                 alarma_prox;
    logic                 no_reconocida_prox;
    logic                 indicador_prox;
    logic [W_EVENTOS-1:0] cnt_eventos_prox;
    logic                 corre;
    logic                 fase_sig;

    assign corre = alarma & ~ack;

    divisor_parpadeo #(
        .DIV (DIV_PARPADEO)
    ) u_divisor (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (corre),
        .clear    (~corre),
        .fase_sig (fase_sig)
    );

    // Next state, debounce counters, ack latch, event counter and output values.
    always_comb begin
        estado_prox  = estado;
        cnt_act_prox = cnt_act;
        cnt_des_prox = cnt_des;

        if (muestra_valida) begin
            case (estado)
                NORMAL: begin
                    if (fuera_rango) begin
                        if (N_ACTIVAR == 1) begin
                            estado_prox  = ALARMA;
                            cnt_act_prox = '0;
                        end else begin
                            estado_prox  = SOSPECHA;
                            cnt_act_prox = W_ACT'(1);
                        end
                    end
                end
                SOSPECHA: begin
                    if (fuera_rango) begin
                        if (cnt_act == W_ACT'(N_ACTIVAR - 1)) begin
                            estado_prox  = ALARMA;
                            cnt_act_prox = '0;
                        end else begin
                            cnt_act_prox = cnt_act + 1'b1;
                        end
                    end else begin
                        estado_prox  = NORMAL;
                        cnt_act_prox = '0;
                    end
                end
                ALARMA: begin
                    if (!fuera_rango) begin
                        if (N_DESACTIVAR == 1) begin
                            estado_prox  = NORMAL;
                            cnt_des_prox = '0;
                        end else begin
                            estado_prox  = RECUPERACION;
                            cnt_des_prox = W_DES'(1);
                        end
                    end
                end
                RECUPERACION: begin
                    if (!fuera_rango) begin
                        if (cnt_des == W_DES'(N_DESACTIVAR - 1)) begin
                            estado_prox  = NORMAL;
                            cnt_des_prox = '0;
                        end else begin
                            cnt_des_prox = cnt_des + 1'b1;
                        end
                    end else begin
                        // Relapse during recovery: same episode, not a new event.
                        estado_prox  = ALARMA;
                        cnt_des_prox = '0;
                    end
                end
                default: begin
                    estado_prox  = NORMAL;
                    cnt_act_prox = '0;
                    cnt_des_prox = '0;
                end
            endcase
        end

        alarma_prox = (estado_prox == ALARMA) || (estado_prox == RECUPERACION);

        // Acknowledge only counts against the registered alarm; leaving to NORMAL wins.
        ack_prox = ack;
        if ((estado_prox == NORMAL) && (estado != NORMAL)) begin
            ack_prox = 1'b0;
        end else if (reconocer && alarma) begin
            ack_prox = 1'b1;
        end

        cnt_eventos_prox = cnt_eventos;
        if ((estado_prox == ALARMA) && ((estado == NORMAL) || (estado == SOSPECHA))
            && (cnt_eventos != '1)) begin
            cnt_eventos_prox = cnt_eventos + 1'b1;
        end

        no_reconocida_prox = alarma_prox & ~ack_prox;
        indicador_prox     = alarma_prox & (ack_prox | ~fase_sig);
    end

    // State register and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= NORMAL;
            cnt_act       <= '0;
            cnt_des       <= '0;
            ack           <= 1'b0;
            alarma        <= 1'b0;
            no_reconocida <= 1'b0;
            indicador     <= 1'b0;
            cnt_eventos   <= '0;
        end else begin
            estado        <= estado_prox;
            cnt_act       <= cnt_act_prox;
            cnt_des       <= cnt_des_prox;
            ack           <= ack_prox;
            alarma        <= alarma_prox;
            no_reconocida <= no_reconocida_prox;
            indicador     <= indicador_prox;
            cnt_eventos   <= cnt_eventos_prox;
        end
    end

endmodule

// File: tb/tb_controlador_alarma.sv
// Directed bench for controlador_alarma with short debounce and blink settings.
module tb_controlador_alarma;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       muestra_valida = 1'b0;
    logic       fuera_rango = 1'b0;
    logic       reconocer = 1'b0;
    logic       alarma;
    logic       no_reconocida;
    logic       indicador;
    logic [1:0] cnt_eventos;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    controlador_alarma #(
        .N_ACTIVAR    (3),
        .N_DESACTIVAR (4),
        .DIV_PARPADEO (4),
        .W_EVENTOS    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .muestra_valida (muestra_valida),
        .fuera_rango    (fuera_rango),
        .reconocer      (reconocer),
        .alarma         (alarma),
        .no_reconocida  (no_reconocida),
        .indicador      (indicador),
        .cnt_eventos    (cnt_eventos)
    );

    task automatic do_reset();
        rst_n          = 1'b0;
        muestra_valida = 1'b0;
        fuera_rango    = 1'b0;
        reconocer      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One valid sample; returns at the negedge after the sampling edge.
    task automatic strobe(input logic v, input logic rec);
        @(negedge clk);
        muestra_valida = 1'b1;
        fuera_rango    = v;
        reconocer      = rec;
        @(negedge clk);
        muestra_valida = 1'b0;
        reconocer      = 1'b0;
    endtask

    task automatic raise_alarm();
        repeat (3) strobe(1'b1, 1'b0);
    endtask

    task automatic clear_alarm();
        repeat (4) strobe(1'b0, 1'b0);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        reconocer = 1'b1;
        @(negedge clk);
        reconocer = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL reset_alarma got=%b exp=0", alarma); end
        n_tests++;
        if (no_reconocida !== 1'b0) begin n_fail++; $display("FAIL reset_no_rec got=%b exp=0", no_reconocida); end
        n_tests++;
        if (indicador !== 1'b0) begin n_fail++; $display("FAIL reset_indicador got=%b exp=0", indicador); end
        n_tests++;
        if (cnt_eventos !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt_eventos); end
    endtask

    task automatic test_activacion();
        do_reset();
        strobe(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL act_tras1 got=%b exp=0", alarma); end
        strobe(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL act_tras2 got=%b exp=0", alarma); end
        pulse_ack();
        // Acknowledge in the raising cycle must not take effect.
        strobe(1'b1, 1'b1);
        n_tests++;
        if (alarma !== 1'b1) begin n_fail++; $display("FAIL act_tras3 got=%b exp=1", alarma); end
        n_tests++;
        if (cnt_eventos !== 2'd1) begin n_fail++; $display("FAIL act_cnt got=%0d exp=1", cnt_eventos); end
        n_tests++;
        if (no_reconocida !== 1'b1) begin n_fail++; $display("FAIL act_no_rec got=%b exp=1", no_reconocida); end
        n_tests++;
        if (indicador !== 1'b1) begin n_fail++; $display("FAIL act_indicador got=%b exp=1", indicador); end
        @(negedge clk);
        n_tests++;
        if (no_reconocida !== 1'b1) begin n_fail++; $display("FAIL act_no_rec_luego got=%b exp=1", no_reconocida); end
    endtask

    task automatic test_rebote();
        logic patron [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            strobe(patron[i], 1'b0);
            n_tests++;
            if (alarma !== 1'b0) begin n_fail++; $display("FAIL rebote_%0d got=%b exp=0", i, alarma); end
        end
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL rebote_reinicio got=%b exp=0", alarma); end
        strobe(1'b1, 1'b0);
        n_tests++;
        if (alarma !== 1'b1) begin n_fail++; $display("FAIL rebote_final got=%b exp=1", alarma); end
    endtask

    task automatic test_parpadeo();
        logic exp_ind;
        do_reset();
        raise_alarm();
        for (int i = 0; i < 12; i++) begin
            exp_ind = ((i % 8) < 4);
            n_tests++;
            if (indicador !== exp_ind) begin n_fail++; $display("FAIL parpadeo_%0d got=%b exp=%b", i, indicador, exp_ind); end
            @(negedge clk);
        end
        reconocer = 1'b1;
        @(negedge clk);
        reconocer = 1'b0;
        n_tests++;
        if (no_reconocida !== 1'b0) begin n_fail++; $display("FAIL ack_no_rec got=%b exp=0", no_reconocida); end
        n_tests++;
        if (alarma !== 1'b1) begin n_fail++; $display("FAIL ack_alarma got=%b exp=1", alarma); end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (indicador !== 1'b1) begin n_fail++; $display("FAIL ack_fijo_%0d got=%b exp=1", i, indicador); end
            @(negedge clk);
        end
    endtask

    task automatic test_recuperacion();
        do_reset();
        raise_alarm();
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, 1'b0);
            n_tests++;
            if (alarma !== 1'b1) begin n_fail++; $display("FAIL recup_a_%0d got=%b exp=1", i, alarma); end
        end
        strobe(1'b1, 1'b0);
        n_tests++;
        if (alarma !== 1'b1) begin n_fail++; $display("FAIL recup_recaida got=%b exp=1", alarma); end
        n_tests++;
        if (cnt_eventos !== 2'd1) begin n_fail++; $display("FAIL recup_cnt got=%0d exp=1", cnt_eventos); end
        pulse_ack();
        n_tests++;
        if (no_reconocida !== 1'b0) begin n_fail++; $display("FAIL recup_ack got=%b exp=0", no_reconocida); end
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, 1'b0);
            n_tests++;
            if (alarma !== 1'b1) begin n_fail++; $display("FAIL recup_b_%0d got=%b exp=1", i, alarma); end
        end
        strobe(1'b0, 1'b0);
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL recup_fin got=%b exp=0", alarma); end
        n_tests++;
        if (indicador !== 1'b0) begin n_fail++; $display("FAIL recup_indicador got=%b exp=0", indicador); end
        raise_alarm();
        n_tests++;
        if (no_reconocida !== 1'b1) begin n_fail++; $display("FAIL recup_ack_borrado got=%b exp=1", no_reconocida); end
        n_tests++;
        if (cnt_eventos !== 2'd2) begin n_fail++; $display("FAIL recup_cnt2 got=%0d exp=2", cnt_eventos); end
    endtask

    task automatic test_saturacion();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int e = 0; e < 5; e++) begin
            raise_alarm();
            n_tests++;
            if (cnt_eventos !== exp_cnt[e]) begin n_fail++; $display("FAIL sat_ep%0d got=%0d exp=%0d", e, cnt_eventos, exp_cnt[e]); end
            clear_alarm();
            n_tests++;
            if (alarma !== 1'b0) begin n_fail++; $display("FAIL sat_clr%0d got=%b exp=0", e, alarma); end
        end
    endtask

    task automatic test_reset_async();
        do_reset();
        raise_alarm();
        repeat (5) @(negedge clk);
        fuera_rango = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL rasync_alarma got=%b exp=0", alarma); end
        n_tests++;
        if (no_reconocida !== 1'b0) begin n_fail++; $display("FAIL rasync_no_rec got=%b exp=0", no_reconocida); end
        n_tests++;
        if (indicador !== 1'b0) begin n_fail++; $display("FAIL rasync_indicador got=%b exp=0", indicador); end
        n_tests++;
        if (cnt_eventos !== 2'd0) begin n_fail++; $display("FAIL rasync_cnt got=%0d exp=0", cnt_eventos); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        n_tests++;
        if (alarma !== 1'b0) begin n_fail++; $display("FAIL rasync_re2 got=%b exp=0", alarma); end
        strobe(1'b1, 1'b0);
        n_tests++;
        if (alarma !== 1'b1) begin n_fail++; $display("FAIL rasync_re3 got=%b exp=1", alarma); end
        n_tests++;
        if (cnt_eventos !== 2'd1) begin n_fail++; $display("FAIL rasync_cnt_re got=%0d exp=1", cnt_eventos); end
    endtask

    task automatic test_sin_valida();
        do_reset();
        muestra_valida = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            fuera_rango = ~fuera_rango;
            n_tests++;
            if ({alarma, no_reconocida, indicador, cnt_eventos} !== 5'b0) begin
                n_fail++;
                $display("FAIL sinval_normal_%0d got=%b exp=00000", i, {alarma, no_reconocida, indicador, cnt_eventos});
            end
        end
        raise_alarm();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fuera_rango = ~fuera_rango;
        end
        n_tests++;
        if (alarma !== 1'b1) begin n_fail++; $display("FAIL sinval_alarma got=%b exp=1", alarma); end
        n_tests++;
        if (cnt_eventos !== 2'd1) begin n_fail++; $display("FAIL sinval_cnt got=%0d exp=1", cnt_eventos); end
    endtask

    initial begin
        test_reset();
        test_activacion();
        test_rebote();
        test_parpadeo();
        test_recuperacion();
        test_saturacion();
        test_reset_async();
        test_sin_valida();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
